// File: rtl/demux3_pkg.sv
// Shared types and constants for the one-to-three stream demultiplexer.
// Destination select encoding plus a one-hot decode helper used by the top.
package demux3_pkg;

    typedef logic [1:0] sel_t;

    localparam sel_t SEL_Y0      = 2'd0;
    localparam sel_t SEL_Y1      = 2'd1;
    localparam sel_t SEL_Y2      = 2'd2;
    localparam sel_t SEL_ILLEGAL = 2'd3;

    // Illegal select decodes to no destination at all.
    function automatic logic [2:0] sel_onehot(input sel_t sel);
        logic [2:0] hot;
        case (sel)
            SEL_Y0:  hot = 3'b001;
            SEL_Y1:  hot = 3'b010;
            SEL_Y2:  hot = 3'b100;
            default: hot = 3'b000;
        endcase
        return hot;
    endfunction

    function automatic logic sel_is_legal(input sel_t sel);
        return (sel != SEL_ILLEGAL);
    endfunction

endpackage

// File: rtl/demux3_stream_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
// Cleared only by the asynchronous reset.
module sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] cnt_r;

    // Count increments, stopping at the maximum value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_r <= {CNT_WIDTH{1'b0}};
        end else if (i_inc && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign o_cnt = cnt_r;

endmodule

// File: rtl/demux3_stream.sv
// One-to-three valid/ready demultiplexer with a single-beat registered buffer.
// Per-output saturating counters track delivered beats for debug.
module demux3_stream
    import demux3_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [1:0]            i_sel,
    output logic [DATA_WIDTH-1:0] o_y0,
    output logic [DATA_WIDTH-1:0] o_y1,
    output logic [DATA_WIDTH-1:0] o_y2,
    output logic                  o_valid0,
    output logic                  o_valid1,
    output logic                  o_valid2,
    input  logic                  i_ready0,
    input  logic                  i_ready1,
    input  logic                  i_ready2,
    output logic                  o_err,
    output logic [CNT_WIDTH-1:0]  o_cnt0,
    output logic [CNT_WIDTH-1:0]  o_cnt1,
    output logic [CNT_WIDTH-1:0]  o_cnt2
);

    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    // The buffer is held directly in the output registers: the one-hot valid
    // vector encodes both "full" and the held select.
    logic [2:0]            valid_r;
    logic [DATA_WIDTH-1:0] y0_r;
    logic [DATA_WIDTH-1:0] y1_r;
    logic [DATA_WIDTH-1:0] y2_r;
    logic                  err_r;

    logic [2:0] sel_hot_s;
    logic [2:0] inc_s;
    logic       full_s;
    logic       drain_s;
    logic       ready_s;
    logic       accept_s;
    logic       illegal_s;
    logic       load_s;

    // Handshake decode: only the selected consumer's ready can drain the beat.
    always_comb begin
        sel_hot_s = sel_onehot(sel_t'(i_sel));
        inc_s     = valid_r & {i_ready2, i_ready1, i_ready0};
        full_s    = |valid_r;
        drain_s   = |inc_s;
        ready_s   = !full_s || drain_s;
        accept_s  = i_valid && ready_s;
        illegal_s = accept_s && !sel_is_legal(sel_t'(i_sel));
        load_s    = accept_s && sel_is_legal(sel_t'(i_sel));
    end

    // Buffer/output registers: load a legal beat, otherwise empty on drain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_r <= 3'b000;
            y0_r    <= DATA_ZERO;
            y1_r    <= DATA_ZERO;
            y2_r    <= DATA_ZERO;
            err_r   <= 1'b0;
        end else begin
            err_r <= illegal_s;
            if (load_s) begin
                valid_r <= sel_hot_s;
                y0_r    <= sel_hot_s[0] ? i_data : DATA_ZERO;
                y1_r    <= sel_hot_s[1] ? i_data : DATA_ZERO;
                y2_r    <= sel_hot_s[2] ? i_data : DATA_ZERO;
            end else if (drain_s) begin
                valid_r <= 3'b000;
                y0_r    <= DATA_ZERO;
                y1_r    <= DATA_ZERO;
                y2_r    <= DATA_ZERO;
            end else begin
                valid_r <= valid_r;
                y0_r    <= y0_r;
                y1_r    <= y1_r;
                y2_r    <= y2_r;
            end
        end
    end

    assign o_ready  = ready_s;
    assign o_valid0 = valid_r[0];
    assign o_valid1 = valid_r[1];
    assign o_valid2 = valid_r[2];
    assign o_y0     = y0_r;
    assign o_y1     = y1_r;
    assign o_y2     = y2_r;
    assign o_err    = err_r;

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt0 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (inc_s[0]),
        .o_cnt   (o_cnt0)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (inc_s[1]),
        .o_cnt   (o_cnt1)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_inc   (inc_s[2]),
        .o_cnt   (o_cnt2)
    );

endmodule

// File: doc/demux3_stream.md
Name: demux3_stream

Overview:
- One-to-three demultiplexer with a registered output stage and a valid/ready handshake on every side.
- It is the fan-out counterpart of the 3-input datapath mux: it routes one producer stream to one of three consumers, chosen per beat by a 2-bit select.
- It sits between the single-cycle core's result path and its three write-side consumers (register-file write port, store buffer, debug/trace sink).
- It holds exactly one beat, and keeps saturating per-output beat counters for debug.

Parameters:
- DATA_WIDTH, 32, width of the data beat.
- CNT_WIDTH, 8, width of each per-output delivered-beat counter.

Ports:
- i_clk, input, 1, clock; all state updates on the rising edge.
- i_rst_n, input, 1, asynchronous active-low reset.
- i_valid, input, 1, producer beat valid.
- o_ready, output, 1, block can accept a beat this cycle.
- i_data, input, DATA_WIDTH, producer beat data.
- i_sel, input, 2, destination: 0→y0, 1→y1, 2→y2, 3 illegal.
- o_y0 / o_y1 / o_y2, output, DATA_WIDTH each, consumer data.
- o_valid0 / o_valid1 / o_valid2, output, 1 each, consumer beat valid.
- i_ready0 / i_ready1 / i_ready2, input, 1 each, consumer accepts.
- o_err, output, 1, one-cycle pulse when an illegal-select beat is dropped.
- o_cnt0 / o_cnt1 / o_cnt2, output, CNT_WIDTH each, saturating count of beats delivered on each output.

Behaviour:
- Reset (async, i_rst_n=0):
  - buffer empty; o_valid0..2=0; o_y0..2=0; o_err=0; o_cnt0..2=0.
  - o_ready=1 immediately after reset release.
- Storage: one buffer register {full, sel, data}. States are EMPTY and FULL, encoded by full.
- Accept: producer beat accepted when i_valid & o_ready.
- o_ready is combinational: o_ready = !full | drain.
  - drain = full & i_ready[sel_q] (the held beat leaves this cycle).
  - This gives full throughput with no bubble.
- Transitions:
  - EMPTY, accept legal → FULL.
  - FULL, drain without accept → EMPTY.
  - FULL, drain with accept → FULL holding the new beat.
  - FULL, no drain → FULL; no accept, since o_ready=0.
- Latency: a beat accepted on edge N appears on its output from cycle N+1 (one-cycle registered latency).
- Outputs:
  - o_valid[k] = full & (sel_q==k).
  - o_y[k] = data_q when sel_q==k, else 0. Unselected outputs are driven to 0, never stale data.
- Stability: while o_valid[k]=1 and i_ready[k]=0, o_y[k] and o_valid[k] stay constant.
- Consumer isolation:
  - i_ready of non-selected outputs is ignored.
  - A consumer dropping ready stalls only the producer, never another output.
- Illegal select (i_sel=3):
  - The beat is accepted (consumed from the producer) but discarded; the buffer is not loaded.
  - o_err=1 for the following cycle only.
  - If it arrives together with a drain, the buffer goes EMPTY as normal.
- Counters:
  - o_cnt[k] increments on each drain on output k.
  - Saturates at 2^CNT_WIDTH-1; no wrap.
  - Cleared only by reset.
- Producer obligations: i_data and i_sel are sampled only on accept; their values when i_valid=0 are don't-care.
- Reset mid-operation: any held beat is lost; no output asserts valid in the cycle reset asserts. Counters and o_err clear.
- Data width: no arithmetic on data; the beat is passed bit-exact.

Decomposition:
- Shared package demux3_pkg holds:
  - typedef sel_t (logic [1:0]);
  - localparams SEL_Y0=0, SEL_Y1=1, SEL_Y2=2, SEL_ILLEGAL=3.
- One sub-module, sat_counter (parameter CNT_WIDTH; ports i_clk, i_rst_n, i_inc, o_cnt), instantiated three times.
- Buffer, ready logic and output decode stay in the top module.

Test Plan:
- Reset then single beat: i_data=AAAAAAAA, i_sel=0, i_ready0=1 → o_valid0=1 with o_y0=AAAAAAAA on the next cycle; o_valid1/2=0 with o_y1/o_y2=0; o_cnt0=1 after drain.
- Back-to-back routing: beats 55555555→sel1, BBBBBBBB→sel2, 12345678→sel0 on consecutive cycles, all readies high → each appears one cycle after accept on the correct output; o_ready stays 1; cnt0=cnt1=cnt2=1.
- Backpressure: beat 87654321→sel2 with i_ready2=0 for 4 cycles → o_valid2 and o_y2 stable, o_ready=0; i_ready0/1 toggling has no effect; i_ready2=1 → drains, o_ready=1.
- Illegal select: i_sel=3, i_data=A76ABC43 → o_err pulses for exactly one cycle; no o_valid asserts; counters unchanged; next legal beat routes normally.
- Saturation: with CNT_WIDTH=4, deliver 20 beats on y1 → o_cnt1 reads 15 and holds there.
- Async reset mid-operation: buffer full (sel0, i_ready0=0); assert i_rst_n=0 between clock edges → o_valid0 falls immediately, all counters read 0, o_ready=1 after release.
